// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and helpers for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } stateT;

    // Working width of the negate helper; callers zero-extend into it and
    // size-cast the result back, so WIDTH may be at most NEG_W/2.
    localparam int NEG_W = 128;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [NEG_W-1:0] condNeg(input logic [NEG_W-1:0] value,
                                                 input logic             neg);
        return neg ? (~value + NEG_W'(1)) : value;
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one combinational shift-add / restoring-divide step
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   accNext
);

    // Multiply layout: acc = {upper partial product (WIDTH+1), remaining multiplier bits}.
    // Divide layout:   acc = {remainder (WIDTH+1), dividend/quotient bits}.
    logic [WIDTH:0]   mulSum;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   remTrial;
    logic             divOk;

    // Compute both candidate steps and pick the one for the current mode.
    always_comb begin
        mulSum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:0], 1'b0};
        remTrial = shifted[2*WIDTH:WIDTH] - {1'b0, operand};
        divOk    = (shifted[2*WIDTH:WIDTH] >= {1'b0, operand});
        if (mode) begin
            accNext = divOk ? {remTrial, shifted[WIDTH-1:1], 1'b1} : shifted;
        end else begin
            accNext = {1'b0, mulSum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide with HI/LO results
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 1;

    stateT            state;
    stateT            stateNext;
    logic             accept;
    logic             finish;
    logic             lastIter;

    logic [CNT_W-1:0] iterCnt;
    logic [1:0]       opReg;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] dividendRaw;
    logic [WIDTH-1:0] operandReg;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    accNext;

    logic             inSigned;
    logic             inDiv;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic             regDiv;

    logic [PW-1:0]    product;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;

    assign inSigned = isSignedOp(op);
    assign inDiv    = isDivOp(op);
    assign absA     = WIDTH'(condNeg(NEG_W'(op_a), inSigned && op_a[WIDTH-1]));
    assign absB     = WIDTH'(condNeg(NEG_W'(op_b), inSigned && op_b[WIDTH-1]));
    assign regDiv   = isDivOp(opReg);
    assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));
    assign busy     = (state != ST_IDLE);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) uIter (
        .mode    (regDiv),
        .acc     (acc),
        .operand (operandReg),
        .accNext (accNext)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: abort beats start and beats completion; start only counts in IDLE.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    stateNext = ST_RUN;
                    accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    stateNext = ST_IDLE;
                end else if (lastIter) begin
                    stateNext = ST_FIX;
                end
            end
            ST_FIX: begin
                stateNext = ST_IDLE;
                finish    = !abort;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Sign fix-up of the magnitude result; a zero divisor forces the MIPS-style pattern.
    always_comb begin
        product = '0;
        resHi   = '0;
        resLo   = '0;
        if (regDiv) begin
            if (div_by_zero) begin
                resLo = '1;
                resHi = dividendRaw;
            end else begin
                resLo = WIDTH'(condNeg(NEG_W'(acc[WIDTH-1:0]), signA ^ signB));
                resHi = WIDTH'(condNeg(NEG_W'(acc[PW-1:WIDTH]), signA));
            end
        end else begin
            product = PW'(condNeg(NEG_W'(acc[PW-1:0]), signA ^ signB));
            resHi   = product[PW-1:WIDTH];
            resLo   = product[WIDTH-1:0];
        end
    end

    // Operand capture, iteration stepping and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iterCnt     <= '0;
            opReg       <= '0;
            signA       <= 1'b0;
            signB       <= 1'b0;
            dividendRaw <= '0;
            operandReg  <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                iterCnt     <= '0;
                opReg       <= op;
                signA       <= inSigned && op_a[WIDTH-1];
                signB       <= inSigned && op_b[WIDTH-1];
                dividendRaw <= op_a;
                // Divide walks the dividend through the low half; multiply walks the multiplier.
                operandReg  <= inDiv ? absB : absA;
                acc         <= {{(WIDTH + 1){1'b0}}, (inDiv ? absA : absB)};
                div_by_zero <= inDiv && (op_b == '0);
            end else if (state == ST_RUN && !abort) begin
                acc     <= accNext;
                iterCnt <= iterCnt + CNT_W'(1);
            end
            if (finish) begin
                hi <= resHi;
                lo <= resLo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at WIDTH 32 and 8
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } expT;

    expT sb32[$];
    expT sb8[$];
    expT lastExp32;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, abort32, busy32, done32, dbz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, abort8, busy8, done8, dbz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .op_a(a32), .op_b(b32),
        .abort(abort32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32),
        .div_by_zero(dbz32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
        .abort(abort8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8),
        .div_by_zero(dbz8)
    );

    function automatic expT refModel(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b, input int w);
        logic [63:0] mask, ua, ub, up;
        longint      sa, sb, sq, sr;
        expT         r;
        mask  = (64'd1 << w) - 64'd1;
        ua    = {32'd0, a} & mask;
        ub    = {32'd0, b} & mask;
        sa    = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb    = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        r.dbz = 1'b0;
        up    = 64'd0;
        case (o)
            OP_MULT:  up = 64'(sa * sb);
            OP_MULTU: up = ua * ub;
            default:  up = 64'd0;
        endcase
        r.lo = 32'(up & mask);
        r.hi = 32'((up >> w) & mask);
        if (o == OP_DIV || o == OP_DIVU) begin
            if (ub == 64'd0) begin
                r.dbz = 1'b1;
                r.lo  = 32'(mask);
                r.hi  = 32'(ua);
            end else if (o == OP_DIV) begin
                sq   = sa / sb;
                sr   = sa % sb;
                r.lo = 32'(64'(sq) & mask);
                r.hi = 32'(64'(sr) & mask);
            end else begin
                r.lo = 32'((ua / ub) & mask);
                r.hi = 32'((ua % ub) & mask);
            end
        end
        return r;
    endfunction

    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input bit hold, input bit track);
        @(posedge clk); #1;
        start32 = 1'b1; op32 = o; a32 = a; b32 = b;
        if (track) sb32.push_back(refModel(o, a, b, 32));
        @(posedge clk); #1;
        if (!hold) start32 = 1'b0;
    endtask

    task automatic finish32(input int startEdges, output int edges, output bit busyOk,
                            output expT e);
        edges  = startEdges;
        busyOk = 1'b1;
        while (done32 !== 1'b1 && edges < 200) begin
            if (busy32 !== 1'b1) busyOk = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        if (sb32.size() > 0) e = sb32.pop_front();
        else e = '{hi: 32'hDEAD_BEEF, lo: 32'hDEAD_BEEF, dbz: 1'b1};
        lastExp32 = e;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        sb8.push_back(refModel(o, {24'd0, a}, {24'd0, b}, 8));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic finish8(output int edges, output expT e);
        edges = 0;
        while (done8 !== 1'b1 && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        if (sb8.size() > 0) e = sb8.pop_front();
        else e = '{hi: 32'hDEAD_BEEF, lo: 32'hDEAD_BEEF, dbz: 1'b1};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start32 = 1'b0; abort32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        start8 = 1'b0; abort8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        lastExp32 = '{hi: 32'd0, lo: 32'd0, dbz: 1'b0};
        #12;
        checks++;
        if ({busy32, done32, dbz32, hi32, lo32} !== 67'd0) begin
            errors++;
            $display("FAIL reset32: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0",
                     busy32, done32, dbz32, hi32, lo32);
        end
        checks++;
        if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0",
                     busy8, done8, dbz8, hi8, lo8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_multu();
        int edges; bit busyOk; expT e;
        issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        finish32(0, edges, busyOk, e);
        checks++;
        if (edges !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", edges); end
        checks++;
        if (!busyOk || busy32 !== 1'b0) begin
            errors++; $display("FAIL multu_busy: got busyOk=%b busyAtDone=%b expected 1/0", busyOk, busy32);
        end
        checks++;
        if (hi32 !== e.hi || lo32 !== e.lo) begin
            errors++; $display("FAIL multu_result: got %h_%h expected %h_%h", hi32, lo32, e.hi, e.lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done32 !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done32); end
    endtask

    task automatic test_signed();
        int edges; bit busyOk; expT e;
        issue32(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b1);
        finish32(0, edges, busyOk, e);
        checks++;
        if (hi32 !== e.hi || lo32 !== e.lo) begin
            errors++; $display("FAIL mult_signed: got %h_%h expected %h_%h", hi32, lo32, e.hi, e.lo);
        end
        issue32(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1);
        finish32(0, edges, busyOk, e);
        checks++;
        if (hi32 !== e.hi || lo32 !== e.lo || dbz32 !== e.dbz) begin
            errors++; $display("FAIL div_signed: got %h_%h dbz=%b expected %h_%h dbz=%b",
                               hi32, lo32, dbz32, e.hi, e.lo, e.dbz);
        end
    endtask

    task automatic test_div_edges();
        int edges; bit busyOk; expT e;
        issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        finish32(0, edges, busyOk, e);
        checks++;
        if (hi32 !== e.hi || lo32 !== e.lo || dbz32 !== e.dbz) begin
            errors++; $display("FAIL div_overflow: got %h_%h dbz=%b expected %h_%h dbz=%b",
                               hi32, lo32, dbz32, e.hi, e.lo, e.dbz);
        end
        issue32(OP_DIVU, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b1);
        finish32(0, edges, busyOk, e);
        checks++;
        if (hi32 !== e.hi || lo32 !== e.lo || dbz32 !== e.dbz) begin
            errors++; $display("FAIL div_by_zero: got %h_%h dbz=%b expected %h_%h dbz=%b",
                               hi32, lo32, dbz32, e.hi, e.lo, e.dbz);
        end
        checks++;
        if (edges !== 33) begin errors++; $display("FAIL dbz_latency: got %0d expected 33", edges); end
        issue32(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0000, 1'b0, 1'b1);
        finish32(0, edges, busyOk, e);
        checks++;
        if (hi32 !== e.hi || lo32 !== e.lo || dbz32 !== e.dbz) begin
            errors++; $display("FAIL div_by_zero_signed: got %h_%h dbz=%b expected %h_%h dbz=%b",
                               hi32, lo32, dbz32, e.hi, e.lo, e.dbz);
        end
    endtask

    task automatic test_back_to_back();
        int edges; bit busyOk; expT e;
        issue32(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start32 = 1'b1; op32 = OP_DIV; a32 = 32'h0000_0001; b32 = 32'h0000_0000;
        @(posedge clk); #1;
        start32 = 1'b0;
        finish32(5, edges, busyOk, e);
        checks++;
        if (edges !== 33 || hi32 !== e.hi || lo32 !== e.lo || dbz32 !== 1'b0) begin
            errors++; $display("FAIL start_ignored: got edges=%0d %h_%h dbz=%b expected 33 %h_%h dbz=0",
                               edges, hi32, lo32, dbz32, e.hi, e.lo);
        end
        issue32(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        op32 = OP_DIVU; a32 = 32'h0000_03E8; b32 = 32'h0000_0007;
        sb32.push_back(refModel(OP_DIVU, 32'h0000_03E8, 32'h0000_0007, 32));
        finish32(0, edges, busyOk, e);
        checks++;
        if (edges !== 33 || hi32 !== e.hi || lo32 !== e.lo) begin
            errors++; $display("FAIL held_first: got edges=%0d %h_%h expected 33 %h_%h",
                               edges, hi32, lo32, e.hi, e.lo);
        end
        @(posedge clk); #1;
        start32 = 1'b0;
        checks++;
        if (busy32 !== 1'b1) begin errors++; $display("FAIL held_accept: got busy=%b expected 1", busy32); end
        finish32(0, edges, busyOk, e);
        checks++;
        if (edges !== 33 || hi32 !== e.hi || lo32 !== e.lo) begin
            errors++; $display("FAIL held_second: got edges=%0d %h_%h expected 33 %h_%h",
                               edges, hi32, lo32, e.hi, e.lo);
        end
    endtask

    task automatic test_width8();
        int edges; expT e;
        issue8(OP_MULTU, 8'hFF, 8'hFF);
        finish8(edges, e);
        checks++;
        if (edges !== 9 || hi8 !== e.hi[7:0] || lo8 !== e.lo[7:0]) begin
            errors++; $display("FAIL w8_multu: got edges=%0d %h_%h expected 9 %h_%h",
                               edges, hi8, lo8, e.hi[7:0], e.lo[7:0]);
        end
        issue8(OP_DIVU, 8'hC8, 8'h07);
        finish8(edges, e);
        checks++;
        if (hi8 !== e.hi[7:0] || lo8 !== e.lo[7:0]) begin
            errors++; $display("FAIL w8_divu: got %h_%h expected %h_%h", hi8, lo8, e.hi[7:0], e.lo[7:0]);
        end
        issue8(OP_DIV, 8'h80, 8'hFF);
        finish8(edges, e);
        checks++;
        if (hi8 !== e.hi[7:0] || lo8 !== e.lo[7:0]) begin
            errors++; $display("FAIL w8_div_overflow: got %h_%h expected %h_%h", hi8, lo8, e.hi[7:0], e.lo[7:0]);
        end
    endtask

    task automatic test_abort();
        bit sawDone;
        issue32(OP_MULTU, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        abort32 = 1'b1;
        @(posedge clk); #1;
        abort32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy32); end
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone || hi32 !== lastExp32.hi || lo32 !== lastExp32.lo) begin
            errors++; $display("FAIL abort_hold: got done=%b %h_%h expected done=0 %h_%h",
                               sawDone, hi32, lo32, lastExp32.hi, lastExp32.lo);
        end
        abort32 = 1'b1; start32 = 1'b1; op32 = OP_MULTU; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk); #1;
        abort32 = 1'b0; start32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0) begin errors++; $display("FAIL abort_priority: got busy=%b expected 0", busy32); end
    endtask

    task automatic test_reset_midrun();
        bit sawDone;
        issue32(OP_DIVU, 32'hFFFF_0000, 32'h0000_0003, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy32, done32, dbz32, hi32, lo32} !== 67'd0) begin
            errors++; $display("FAIL reset_midrun: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all 0",
                               busy32, done32, dbz32, hi32, lo32);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 === 1'b1 || busy32 === 1'b1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin errors++; $display("FAIL reset_no_done: got activity=1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_signed();
        test_div_edges();
        test_back_to_back();
        test_width8();
        test_abort();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the datapath; this is the multi-cycle companion to the combinational ALU.
- Performs signed and unsigned multiply and divide over WIDTH-bit operands.
- Results go to HI/LO registers, in MIPS MULT/MULTU/DIV/DIVU style.
- Uses a start/busy/done handshake with fixed latency, plus abort for pipeline flush.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
clk  in  1  clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new operation; sampled only when idle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
op_a  in  WIDTH  multiplicand / dividend
op_b  in  WIDTH  multiplier / divisor
abort  in  1  cancel any in-flight operation
busy  out  1  operation in flight
done  out  1  one-cycle pulse; hi/lo valid with this pulse
hi  out  WIDTH  multiply: upper product; divide: remainder
lo  out  WIDTH  multiply: lower product; divide: quotient
div_by_zero  out  1  last accepted divide had op_b == 0

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - hi, lo, busy, done, div_by_zero = 0.
  - FSM = IDLE, counter = 0.
  - Any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, FIX.
- Accept:
  - At edge E0, if state == IDLE, start == 1 and abort == 0: latch op and operands.
  - Signed ops latch |op_a|, |op_b| and record sign_a, sign_b.
  - Go to RUN with counter = 0; busy = 1 from E0.
  - div_by_zero is updated at E0: 1 if op is DIV/DIVU and op_b == 0, else 0.
- RUN: one iteration per edge. Counter increments each edge; after the WIDTH-th iteration (edge E_WIDTH) go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division; shift remainder/quotient left one bit, subtract divisor if remainder >= divisor, quotient bit = 1 on success. Remainder register is WIDTH+1 bits.
- FIX, at edge E_(WIDTH+1):
  - Signed multiply: negate the 2*WIDTH product if sign_a ^ sign_b.
  - Signed divide: negate quotient if sign_a ^ sign_b; negate remainder if sign_a.
  - Write hi/lo, done = 1 for exactly one cycle, busy = 0, go to IDLE.
- Latency: done is high in the cycle following E_(WIDTH+1), i.e. WIDTH+1 edges after acceptance, for every op including divide-by-zero.
- Divide by zero: iterations still run (fixed latency). Final result is forced to lo = all ones, hi = op_a as latched (original, not magnitude).
- Signed overflow: MIN / -1 gives lo = MIN, hi = 0. This falls out naturally because |MIN| fits in WIDTH unsigned bits; no special case.
- start while busy: ignored; no queuing, no state change.
- start in the same cycle as done (state is IDLE): accepted normally.
- abort:
  - Takes priority over start.
  - In RUN or FIX, go to IDLE at the next edge; busy = 0, no done, hi/lo/div_by_zero keep their prior values.
  - abort in IDLE has no effect.
- hi/lo hold their values until the next completed operation. Nothing else writes them.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: ST_IDLE, ST_RUN, ST_FIX;
  - helper function for conditional two's-complement negate.
- Sub-module muldiv_iter: combinational single iteration, parametrised by WIDTH.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator.
  - muldiv_unit instantiates it and keeps the FSM, counter and registers.

Test Plan:
- MULTU, WIDTH=32: op_a = op_b = FFFFFFFF -> hi = FFFFFFFE, lo = 00000001; done exactly 33 edges after accept; busy high throughout.
- MULT: op_a = FFFFFFFD (-3), op_b = 00000005 -> hi = FFFFFFFF, lo = FFFFFFF1. Then DIV: op_a = FFFFFFF9 (-7), op_b = 00000002 -> lo = FFFFFFFD, hi = FFFFFFFF.
- DIV: op_a = 80000000, op_b = FFFFFFFF -> lo = 80000000, hi = 00000000, div_by_zero = 0. Then DIVU: op_a = 00000064, op_b = 0 -> lo = FFFFFFFF, hi = 00000064, div_by_zero = 1, same 33-edge latency.
- start pulsed at edge 5 of a running MULTU -> ignored; result unchanged. start held high across done -> second op accepted in the done cycle; its done follows 33 edges later.
- abort at RUN iteration 10 -> busy = 0 next cycle, no done, hi/lo keep previous result. rst_n low mid-RUN -> all outputs 0 immediately, no done.
- WIDTH=8 instance, MULTU 0xFF × 0xFF -> hi = FE, lo = 01, done 9 edges after accept. DIVU 0xC8 / 0x07 -> lo = 1C, hi = 04.
